// File: rtl/door_lock_seq.sv
// rtl/door_lock_seq.sv - keypad door lock: digit entry, password compare, timed unlock, failure lockout
module door_lock_seq #(
  parameter int DIGITS      = 4,
  parameter int DIGIT_W     = 4,
  parameter int MAX_TRIES   = 3,
  parameter int UNLOCK_CYC  = 500,
  parameter int LOCKOUT_CYC = 1000
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             switch,
  input  logic                             set_pass,
  input  logic [DIGITS*DIGIT_W-1:0]        pass,
  input  logic                             key_valid,
  input  logic [DIGIT_W-1:0]               key_digit,
  input  logic                             key_clear,
  output logic                             unlock,
  output logic                             wrong,
  output logic                             locked_out,
  output logic [$clog2(DIGITS+1)-1:0]      digit_cnt,
  output logic [$clog2(MAX_TRIES+1)-1:0]   fail_cnt
);

  localparam int PW   = DIGITS * DIGIT_W;
  localparam int DCW  = $clog2(DIGITS + 1);
  localparam int FCW  = $clog2(MAX_TRIES + 1);
  localparam int TMAX = (UNLOCK_CYC > LOCKOUT_CYC) ? UNLOCK_CYC : LOCKOUT_CYC;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [DCW-1:0] DIGITS_C       = DCW'(DIGITS);
  localparam logic [FCW-1:0] MAX_TRIES_C    = FCW'(MAX_TRIES);
  localparam logic [TW-1:0]  UNLOCK_LAST_C  = TW'(UNLOCK_CYC - 1);
  localparam logic [TW-1:0]  LOCKOUT_LAST_C = TW'(LOCKOUT_CYC - 1);

  typedef enum logic [2:0] {
    ST_DISARMED = 3'd0,
    ST_ENTRY    = 3'd1,
    ST_CHECK    = 3'd2,
    ST_OPEN     = 3'd3,
    ST_LOCKOUT  = 3'd4
  } state_t;

  state_t         state_q, state_d;
  logic [PW-1:0]  stored_q, stored_d;
  logic [PW-1:0]  buf_q, buf_d;
  logic [DCW-1:0] digit_cnt_q, digit_cnt_d;
  logic [FCW-1:0] fail_cnt_q, fail_cnt_d;
  logic [TW-1:0]  timer_q, timer_d;
  logic           unlock_q, unlock_d;
  logic           wrong_q, wrong_d;
  logic           locked_out_q, locked_out_d;

  // State register and all registered outputs; reset leaves the system disarmed and open
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_DISARMED;
      stored_q     <= '0;
      buf_q        <= '0;
      digit_cnt_q  <= '0;
      fail_cnt_q   <= '0;
      timer_q      <= '0;
      unlock_q     <= 1'b1;
      wrong_q      <= 1'b0;
      locked_out_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      stored_q     <= stored_d;
      buf_q        <= buf_d;
      digit_cnt_q  <= digit_cnt_d;
      fail_cnt_q   <= fail_cnt_d;
      timer_q      <= timer_d;
      unlock_q     <= unlock_d;
      wrong_q      <= wrong_d;
      locked_out_q <= locked_out_d;
    end
  end

  // Next-state and output logic; disarming overrides everything, including an active lockout
  always_comb begin
    state_d      = state_q;
    stored_d     = stored_q;
    buf_d        = buf_q;
    digit_cnt_d  = digit_cnt_q;
    fail_cnt_d   = fail_cnt_q;
    timer_d      = timer_q;
    unlock_d     = unlock_q;
    wrong_d      = 1'b0;
    locked_out_d = locked_out_q;

    // The stored password may only change while the door is legitimately open or disarmed
    if (set_pass && (state_q == ST_DISARMED || state_q == ST_OPEN)) begin
      stored_d = pass;
    end

    if (!switch) begin
      state_d      = ST_DISARMED;
      buf_d        = '0;
      digit_cnt_d  = '0;
      fail_cnt_d   = '0;
      timer_d      = '0;
      unlock_d     = 1'b1;
      locked_out_d = 1'b0;
    end else begin
      case (state_q)
        ST_DISARMED: begin
          state_d  = ST_ENTRY;
          unlock_d = 1'b0;
        end
        ST_ENTRY: begin
          // Clear wins over a simultaneous key so a half-typed code is never completed by accident
          if (key_clear) begin
            buf_d       = '0;
            digit_cnt_d = '0;
          end else if (key_valid) begin
            buf_d = (buf_q << DIGIT_W) | PW'(key_digit);
            if (digit_cnt_q != DIGITS_C) begin
              digit_cnt_d = digit_cnt_q + DCW'(1);
            end
            if (digit_cnt_d == DIGITS_C) begin
              state_d = ST_CHECK;
            end
          end
        end
        ST_CHECK: begin
          buf_d       = '0;
          digit_cnt_d = '0;
          timer_d     = '0;
          if (buf_q == stored_q) begin
            state_d    = ST_OPEN;
            unlock_d   = 1'b1;
            fail_cnt_d = '0;
          end else begin
            wrong_d = 1'b1;
            if (fail_cnt_q != MAX_TRIES_C) begin
              fail_cnt_d = fail_cnt_q + FCW'(1);
            end
            if (fail_cnt_d == MAX_TRIES_C) begin
              state_d      = ST_LOCKOUT;
              locked_out_d = 1'b1;
            end else begin
              state_d = ST_ENTRY;
            end
          end
        end
        ST_OPEN: begin
          if (timer_q == UNLOCK_LAST_C) begin
            state_d  = ST_ENTRY;
            unlock_d = 1'b0;
            timer_d  = '0;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
        ST_LOCKOUT: begin
          if (timer_q == LOCKOUT_LAST_C) begin
            state_d      = ST_ENTRY;
            locked_out_d = 1'b0;
            fail_cnt_d   = '0;
            timer_d      = '0;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
        default: begin
          state_d = ST_DISARMED;
        end
      endcase
    end
  end

  assign unlock     = unlock_q;
  assign wrong      = wrong_q;
  assign locked_out = locked_out_q;
  assign digit_cnt  = digit_cnt_q;
  assign fail_cnt   = fail_cnt_q;

endmodule

// File: tb/tb_door_lock_seq.sv
// tb/tb_door_lock_seq.sv - directed and randomized bench for door_lock_seq against a behavioural model
module tb_door_lock_seq;

  localparam int DIGITS      = 4;
  localparam int DIGIT_W     = 4;
  localparam int MAX_TRIES   = 3;
  localparam int UNLOCK_CYC  = 500;
  localparam int LOCKOUT_CYC = 1000;

  localparam int M_OFF  = 0;
  localparam int M_KEYS = 1;
  localparam int M_EVAL = 2;
  localparam int M_OPEN = 3;
  localparam int M_LOCK = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        switch = 1'b0;
  logic        set_pass = 1'b0;
  logic [15:0] pass = 16'h0;
  logic        key_valid = 1'b0;
  logic [3:0]  key_digit = 4'h0;
  logic        key_clear = 1'b0;
  logic        unlock;
  logic        wrong;
  logic        locked_out;
  logic [2:0]  digit_cnt;
  logic [1:0]  fail_cnt;

  door_lock_seq #(
    .DIGITS(DIGITS), .DIGIT_W(DIGIT_W), .MAX_TRIES(MAX_TRIES),
    .UNLOCK_CYC(UNLOCK_CYC), .LOCKOUT_CYC(LOCKOUT_CYC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .switch(switch), .set_pass(set_pass), .pass(pass),
    .key_valid(key_valid), .key_digit(key_digit), .key_clear(key_clear),
    .unlock(unlock), .wrong(wrong), .locked_out(locked_out),
    .digit_cnt(digit_cnt), .fail_cnt(fail_cnt)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: entered digits kept as a list, timers as cycles remaining
  int          m_mode;
  logic [3:0]  m_keys[$];
  logic [15:0] m_stored;
  int          m_fail;
  int          m_left;
  logic        exp_unlock, exp_wrong, exp_lock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = M_OFF;
    m_keys.delete();
    m_stored = 16'h0;
    m_fail = 0;
    m_left = 0;
    exp_unlock = 1'b1;
    exp_wrong = 1'b0;
    exp_lock = 1'b0;
  endtask

  task automatic model_step();
    int old_mode = m_mode;
    logic [15:0] code_val;
    exp_wrong = 1'b0;
    if (!switch) begin
      m_mode = M_OFF;
      m_keys.delete();
      m_fail = 0;
      m_left = 0;
      exp_unlock = 1'b1;
      exp_lock = 1'b0;
    end else begin
      case (old_mode)
        M_OFF: begin
          m_mode = M_KEYS;
          exp_unlock = 1'b0;
        end
        M_KEYS: begin
          if (key_clear) m_keys.delete();
          else if (key_valid) m_keys.push_back(key_digit);
          if (m_keys.size() == DIGITS) m_mode = M_EVAL;
        end
        M_EVAL: begin
          code_val = 16'h0;
          foreach (m_keys[i]) code_val = {code_val[11:0], m_keys[i]};
          m_keys.delete();
          if (code_val == m_stored) begin
            m_mode = M_OPEN;
            exp_unlock = 1'b1;
            m_fail = 0;
            m_left = UNLOCK_CYC;
          end else begin
            exp_wrong = 1'b1;
            if (m_fail < MAX_TRIES) m_fail++;
            if (m_fail == MAX_TRIES) begin
              m_mode = M_LOCK;
              exp_lock = 1'b1;
              m_left = LOCKOUT_CYC;
            end else begin
              m_mode = M_KEYS;
            end
          end
        end
        M_OPEN: begin
          m_left--;
          if (m_left == 0) begin
            m_mode = M_KEYS;
            exp_unlock = 1'b0;
          end
        end
        default: begin
          m_left--;
          if (m_left == 0) begin
            m_mode = M_KEYS;
            exp_lock = 1'b0;
            m_fail = 0;
          end
        end
      endcase
    end
    if (set_pass && (old_mode == M_OFF || old_mode == M_OPEN)) m_stored = pass;
  endtask

  task automatic check_all();
    check("unlock", 32'(unlock), 32'(exp_unlock));
    check("wrong", 32'(wrong), 32'(exp_wrong));
    check("locked_out", 32'(locked_out), 32'(exp_lock));
    check("digit_cnt", 32'(digit_cnt), 32'(m_keys.size()));
    check("fail_cnt", 32'(fail_cnt), 32'(m_fail));
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step();
    #1;
    check_all();
    key_valid = 1'b0;
    key_clear = 1'b0;
    set_pass = 1'b0;
  endtask

  task automatic press(input logic [3:0] d);
    key_digit = d;
    key_valid = 1'b1;
    tick();
  endtask

  task automatic enter_code(input logic [15:0] c);
    press(c[15:12]);
    press(c[11:8]);
    press(c[7:4]);
    press(c[3:0]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    logic [15:0] sp;
    int idx;
    model_reset();
    #12;
    check("rst_unlock", 32'(unlock), 32'd1);
    check("rst_digit_cnt", 32'(digit_cnt), 32'd0);
    check("rst_fail_cnt", 32'(fail_cnt), 32'd0);
    check("rst_locked_out", 32'(locked_out), 32'd0);
    rst_n = 1'b1;

    // Asynchronous reset in the middle of code entry
    switch = 1'b1;
    tick();
    press(4'd1);
    press(4'd2);
    check("pre_rst_digit_cnt", 32'(digit_cnt), 32'd2);
    rst_n = 1'b0;
    #2;
    check("async_unlock", 32'(unlock), 32'd1);
    check("async_digit_cnt", 32'(digit_cnt), 32'd0);
    check("async_fail_cnt", 32'(fail_cnt), 32'd0);
    model_reset();
    rst_n = 1'b1;

    // Program 1473 while disarmed, then a wrong code
    switch = 1'b0;
    set_pass = 1'b1;
    pass = 16'h1473;
    tick();
    switch = 1'b1;
    tick();
    enter_code(16'h1562);
    check("wrong_not_yet", 32'(wrong), 32'd0);
    tick();
    check("wrong_pulse", 32'(wrong), 32'd1);
    check("wrong_fail_cnt", 32'(fail_cnt), 32'd1);
    check("wrong_unlock", 32'(unlock), 32'd0);
    tick();

    // Correct code opens for exactly UNLOCK_CYC cycles
    enter_code(16'h1473);
    tick();
    check("open_unlock", 32'(unlock), 32'd1);
    check("open_fail_cnt", 32'(fail_cnt), 32'd0);
    idle(UNLOCK_CYC - 1);
    check("open_held", 32'(unlock), 32'd1);
    tick();
    check("open_end", 32'(unlock), 32'd0);

    // Three failures lock out; keys ignored throughout
    for (int k = 0; k < MAX_TRIES; k++) begin
      enter_code(16'h1562);
      tick();
    end
    check("lockout_on", 32'(locked_out), 32'd1);
    for (int i = 0; i < LOCKOUT_CYC - 1; i++) begin
      key_valid = 1'b1;
      key_digit = 4'($urandom_range(0, 15));
      tick();
    end
    check("lockout_held", 32'(locked_out), 32'd1);
    check("lockout_keys_ignored", 32'(digit_cnt), 32'd0);
    tick();
    check("lockout_end", 32'(locked_out), 32'd0);
    check("lockout_fail_clr", 32'(fail_cnt), 32'd0);
    enter_code(16'h1473);
    tick();
    check("post_lockout_unlock", 32'(unlock), 32'd1);
    idle(UNLOCK_CYC);

    // Clear together with a key drops the key
    press(4'd1);
    press(4'd4);
    key_clear = 1'b1;
    key_valid = 1'b1;
    key_digit = 4'd7;
    tick();
    check("clear_wins", 32'(digit_cnt), 32'd0);
    enter_code(16'h1473);
    tick();
    check("clear_then_unlock", 32'(unlock), 32'd1);
    idle(UNLOCK_CYC);

    // set_pass during entry is ignored
    press(4'd1);
    set_pass = 1'b1;
    pass = 16'h9999;
    tick();
    press(4'd4);
    press(4'd7);
    press(4'd3);
    tick();
    check("setpass_ignored", 32'(unlock), 32'd1);
    idle(UNLOCK_CYC);

    // Disarm in the middle of a lockout
    for (int k = 0; k < MAX_TRIES; k++) begin
      enter_code(16'h0000);
      tick();
    end
    idle(10);
    check("mid_lockout", 32'(locked_out), 32'd1);
    switch = 1'b0;
    tick();
    check("disarm_unlock", 32'(unlock), 32'd1);
    check("disarm_lockout_clr", 32'(locked_out), 32'd0);
    check("disarm_fail_clr", 32'(fail_cnt), 32'd0);

    // Randomized traffic, digits biased toward the stored code so matches occur
    for (int i = 0; i < 8000; i++) begin
      switch = ($urandom_range(0, 999) < 997);
      set_pass = ($urandom_range(0, 99) < 3);
      sp = 16'($urandom);
      pass = ($urandom_range(0, 1) == 1) ? 16'h1473 : sp;
      key_valid = ($urandom_range(0, 2) == 0);
      key_clear = ($urandom_range(0, 39) == 0);
      idx = m_keys.size();
      if (idx < DIGITS && $urandom_range(0, 2) != 0) begin
        sp = m_stored;
        key_digit = sp[(DIGITS - 1 - idx) * DIGIT_W +: DIGIT_W];
      end else begin
        key_digit = 4'($urandom_range(0, 15));
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
